// File: rtl/tms34020_cache_pkg.sv
// Shared types and geometry for the TMS34020-style instruction cache fill logic.
// The cache has 4 segments, 8 subsegments per segment and 4 words per subsegment.
package tms34020_cache_pkg;

    localparam int SEG_NUM    = 4;
    localparam int SUBSEG_NUM = 8;
    localparam int LINE_WORDS = 4;
    localparam int SEG_W      = 2;
    localparam int SUBSEG_W   = 3;
    localparam int WORD_W     = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    // Entry 0 holds the most recently used segment; the last entry is the LRU victim.
    typedef logic [SEG_NUM-1:0][SEG_W-1:0] lru_stack_t;

    function automatic logic [6:0] cache_addr(
        input logic [SEG_W-1:0]    seg,
        input logic [SUBSEG_W-1:0] sub,
        input logic [WORD_W-1:0]   word
    );
        return {seg, sub, word};
    endfunction

endpackage

// File: rtl/tms34020_cache_lru.sv
// Four-entry LRU stack: a touch moves the segment to the MRU slot, and the
// bottom of the stack names the replacement victim.
module tms34020_cache_lru
    import tms34020_cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch,
    input  logic [SEG_W-1:0] touch_seg,
    output logic [SEG_W-1:0] lru_seg
);

    lru_stack_t       stack_r;
    lru_stack_t       stack_next_s;
    logic [SEG_W-1:0] pos_s;

    // Locate the touched segment, then shift the more recent entries down by one.
    always_comb begin
        pos_s = {SEG_W{1'b0}};
        for (int i = 0; i < SEG_NUM; i++) begin
            if (stack_r[i] == touch_seg) begin
                pos_s = SEG_W'(i);
            end else begin
                pos_s = pos_s;
            end
        end
        stack_next_s = stack_r;
        if (touch) begin
            stack_next_s[0] = touch_seg;
            for (int i = 1; i < SEG_NUM; i++) begin
                if (i <= int'(pos_s)) begin
                    stack_next_s[i] = stack_r[i-1];
                end else begin
                    stack_next_s[i] = stack_r[i];
                end
            end
        end else begin
            stack_next_s = stack_r;
        end
    end

    // Stack register; reset order is seg0 = MRU down to seg3 = LRU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEG_NUM; i++) begin
                stack_r[i] <= SEG_W'(i);
            end
        end else if (touch) begin
            stack_r <= stack_next_s;
        end else begin
            stack_r <= stack_r;
        end
    end

    assign lru_seg = stack_r[SEG_NUM-1];

endmodule

// File: rtl/tms34020_cache_fill.sv
// Instruction cache lookup and subsegment fill controller (IDLE/FILL).
// Optional hit/miss statistics are built when TMS34020_CACHE_STATS_EN is defined.
module tms34020_cache_fill
    import tms34020_cache_pkg::*;
#(
    parameter int TAG_W = 22
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic        FLUSH,
    input  logic        FETCH_REQ,
    input  logic [31:0] FETCH_ADDR,
    output logic        HIT,
    output logic [6:0]  RADDR,
    output logic        BUSY,
    output logic        BUS_REQ,
    output logic [31:0] BUS_ADDR,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_DATA,
    output logic [6:0]  CWADDR,
    output logic [31:0] CWDATA,
    output logic        CWREN,
    output logic [15:0] HIT_CNT,
    output logic [15:0] MISS_CNT
);

    fill_state_t                             state_r;
    logic [TAG_W-1:0]                        tag_r [SEG_NUM];
    logic [SEG_NUM-1:0][SUBSEG_NUM-1:0]      present_r;
    logic                                    bus_req_r;
    logic [31:0]                             bus_addr_r;
    logic [SEG_W-1:0]                        fill_seg_r;
    logic [SUBSEG_W-1:0]                     fill_sub_r;
    logic [WORD_W-1:0]                       beat_r;
    logic                                    flush_pend_r;

    logic [TAG_W-1:0]    addr_tag_s;
    logic [SUBSEG_W-1:0] addr_sub_s;
    logic [WORD_W-1:0]   addr_word_s;
    logic                tag_match_s;
    logic [SEG_W-1:0]    match_seg_s;
    logic [SEG_W-1:0]    lru_seg_s;
    logic                hit_s;
    logic                start_s;
    logic                ack_s;
    logic                abort_s;
    logic                fill_done_s;
    logic                touch_s;
    logic [SEG_W-1:0]    touch_seg_s;
    logic                unused_addr_s;

    assign addr_tag_s    = FETCH_ADDR[10 +: TAG_W];
    assign addr_sub_s    = FETCH_ADDR[9:7];
    assign addr_word_s   = FETCH_ADDR[6:5];
    assign unused_addr_s = ^FETCH_ADDR[4:0];

    // Tag compare; the lowest-numbered matching segment wins so equal reset tags resolve.
    always_comb begin
        tag_match_s = 1'b0;
        match_seg_s = {SEG_W{1'b0}};
        for (int i = SEG_NUM - 1; i >= 0; i--) begin
            if (tag_r[i] == addr_tag_s) begin
                tag_match_s = 1'b1;
                match_seg_s = SEG_W'(i);
            end else begin
                tag_match_s = tag_match_s;
                match_seg_s = match_seg_s;
            end
        end
    end

    assign hit_s   = EN && FETCH_REQ && (state_r == ST_IDLE) && tag_match_s
                     && present_r[match_seg_s][addr_sub_s];
    assign start_s = EN && FETCH_REQ && (state_r == ST_IDLE) && !hit_s && !FLUSH;

    // In FILL the bus request is always raised, so an ACK here is always a beat completion.
    assign ack_s       = (state_r == ST_FILL) && BUS_ACK;
    assign abort_s     = ack_s && (flush_pend_r || FLUSH);
    assign fill_done_s = ack_s && !abort_s && (beat_r == 2'd3);

    assign touch_s     = hit_s || fill_done_s;
    assign touch_seg_s = hit_s ? match_seg_s : fill_seg_r;

    tms34020_cache_lru u_lru (
        .clk       (CLK),
        .rst_n     (RST_N),
        .touch     (touch_s),
        .touch_seg (touch_seg_s),
        .lru_seg   (lru_seg_s)
    );

    // Fill state machine, tag store and present bits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            present_r    <= {(SEG_NUM*SUBSEG_NUM){1'b0}};
            bus_req_r    <= 1'b0;
            bus_addr_r   <= 32'd0;
            fill_seg_r   <= {SEG_W{1'b0}};
            fill_sub_r   <= {SUBSEG_W{1'b0}};
            beat_r       <= 2'd0;
            flush_pend_r <= 1'b0;
            for (int i = 0; i < SEG_NUM; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (FLUSH) begin
                        present_r <= {(SEG_NUM*SUBSEG_NUM){1'b0}};
                    end else if (start_s) begin
                        if (!tag_match_s) begin
                            tag_r[lru_seg_s]     <= addr_tag_s;
                            present_r[lru_seg_s] <= {SUBSEG_NUM{1'b0}};
                            fill_seg_r           <= lru_seg_s;
                        end else begin
                            fill_seg_r           <= match_seg_s;
                        end
                        fill_sub_r   <= addr_sub_s;
                        beat_r       <= 2'd0;
                        flush_pend_r <= 1'b0;
                        bus_req_r    <= 1'b1;
                        bus_addr_r   <= {FETCH_ADDR[31:7], 7'd0};
                        state_r      <= ST_FILL;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (abort_s) begin
                        present_r    <= {(SEG_NUM*SUBSEG_NUM){1'b0}};
                        flush_pend_r <= 1'b0;
                        bus_req_r    <= 1'b0;
                        bus_addr_r   <= 32'd0;
                        state_r      <= ST_IDLE;
                    end else if (fill_done_s) begin
                        present_r[fill_seg_r][fill_sub_r] <= 1'b1;
                        bus_req_r    <= 1'b0;
                        bus_addr_r   <= 32'd0;
                        state_r      <= ST_IDLE;
                    end else if (ack_s) begin
                        beat_r     <= beat_r + 2'd1;
                        bus_addr_r <= bus_addr_r + 32'd32;
                    end else if (FLUSH) begin
                        flush_pend_r <= 1'b1;
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign HIT      = hit_s;
    assign RADDR    = hit_s ? cache_addr(match_seg_s, addr_sub_s, addr_word_s) : 7'd0;
    assign BUSY     = (state_r == ST_FILL);
    assign BUS_REQ  = bus_req_r;
    assign BUS_ADDR = bus_addr_r;
    assign CWREN    = ack_s;
    assign CWDATA   = ack_s ? BUS_DATA : 32'd0;
    assign CWADDR   = ack_s ? cache_addr(fill_seg_r, fill_sub_r, beat_r) : 7'd0;

`ifdef TMS34020_CACHE_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] miss_cnt_r;

    // Saturating hit/miss counters, cleared by FLUSH in any state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_cnt_r  <= 16'd0;
            miss_cnt_r <= 16'd0;
        end else if (FLUSH) begin
            hit_cnt_r  <= 16'd0;
            miss_cnt_r <= 16'd0;
        end else begin
            if (hit_s && (hit_cnt_r != 16'hFFFF)) begin
                hit_cnt_r <= hit_cnt_r + 16'd1;
            end else begin
                hit_cnt_r <= hit_cnt_r;
            end
            if (start_s && (miss_cnt_r != 16'hFFFF)) begin
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign HIT_CNT  = hit_cnt_r;
    assign MISS_CNT = miss_cnt_r;
`else
    assign HIT_CNT  = 16'd0;
    assign MISS_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_tms34020_cache_fill.sv
// Scoreboard bench for tms34020_cache_fill: expected bus beats and cache writes are
// queued when a miss is issued and popped as the DUT writes the cache RAM.
module tb_tms34020_cache_fill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        hit;
    logic [6:0]  raddr;
    logic        busy;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_data;
    logic [6:0]  cwaddr;
    logic [31:0] cwdata;
    logic        cwren;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    typedef struct {
        logic [31:0] baddr;
        logic [6:0]  cwaddr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ack_delay = 0;
    int   exp_hits = 0;
    int   exp_miss = 0;

    always #5 clk = ~clk;

    tms34020_cache_fill #(.TAG_W(22)) dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .FLUSH(flush),
        .FETCH_REQ(fetch_req), .FETCH_ADDR(fetch_addr),
        .HIT(hit), .RADDR(raddr), .BUSY(busy),
        .BUS_REQ(bus_req), .BUS_ADDR(bus_addr),
        .BUS_ACK(bus_ack), .BUS_DATA(bus_data),
        .CWADDR(cwaddr), .CWDATA(cwdata), .CWREN(cwren),
        .HIT_CNT(hit_cnt), .MISS_CNT(miss_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int stat_exp(input int v);
`ifdef TMS34020_CACHE_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic push_fill(input logic [31:0] addr, input logic [1:0] seg, input int nbeats);
        exp_t e;
        logic [2:0] sub;
        sub = addr[9:7];
        for (int b = 0; b < nbeats; b++) begin
            e.baddr  = {addr[31:7], 7'd0} + 32'(32 * b);
            e.cwaddr = {seg, sub, 2'(b)};
            e.data   = bus_word(e.baddr);
            sb.push_back(e);
        end
    endtask

    task automatic lookup(input logic [31:0] addr, input logic exp_hit, input logic [6:0] exp_raddr);
        fetch_addr = addr;
        fetch_req  = 1'b1;
        #2;
        check_val("hit", 32'(hit), 32'(exp_hit));
        check_val("raddr", 32'(raddr), 32'(exp_raddr));
        if (en) begin
            if (exp_hit) exp_hits++;
            else exp_miss++;
        end
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("fill_done", 32'(busy), 32'd0);
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        check_val("bus_req_idle", 32'(bus_req), 32'd0);
    endtask

    task automatic fill(input logic [31:0] addr, input logic [1:0] seg);
        push_fill(addr, seg, 4);
        lookup(addr, 1'b0, 7'd0);
        wait_idle();
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(stat_exp(exp_hits)));
        check_val({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(stat_exp(exp_miss)));
    endtask

    // Bus slave: acknowledges each request after ack_delay wait cycles.
    initial begin
        int wait_cnt = 0;
        bus_ack  = 1'b0;
        bus_data = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            bus_ack  = 1'b0;
            bus_data = 32'hDEAD_BEEF;
            if (bus_req) begin
                if (wait_cnt >= ack_delay) begin
                    bus_ack  = 1'b1;
                    bus_data = bus_word(bus_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: scoreboard compare on every cache write, plus request stability while unacked.
    initial begin
        exp_t        e;
        logic        prev_req  = 1'b0;
        logic        prev_ack  = 1'b0;
        logic [31:0] prev_addr = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (prev_req && !prev_ack) begin
                    check_val("bus_req_hold", 32'(bus_req), 32'd1);
                    check_val("bus_addr_hold", bus_addr, prev_addr);
                end
                if (cwren) begin
                    if (sb.size() == 0) begin
                        check_val("sb_extra_write", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check_val("bus_addr", bus_addr, e.baddr);
                        check_val("cwaddr", 32'(cwaddr), 32'(e.cwaddr));
                        check_val("cwdata", cwdata, e.data);
                    end
                end
                prev_req  = bus_req;
                prev_ack  = bus_ack;
                prev_addr = bus_addr;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        en         = 1'b1;
        flush      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_bus_req", 32'(bus_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_bus_addr", bus_addr, 32'd0);
        check_val("rst_cwren", 32'(cwren), 32'd0);
        check_val("rst_cwaddr", 32'(cwaddr), 32'd0);
        check_stats("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss: tag 1 lands in seg3 (LRU at reset).
        fill(32'h0000_0400, 2'd3);
        lookup(32'h0000_0400, 1'b1, 7'h60);
        lookup(32'h0000_0440, 1'b1, 7'h62);

        // Same tag, new subsegment: only subseg1 is filled, subseg0 stays present.
        fill(32'h0000_0480, 2'd3);
        lookup(32'h0000_0400, 1'b1, 7'h60);
        lookup(32'h0000_04A0, 1'b1, 7'h65);

        // Back-pressure on every beat.
        ack_delay = 10;
        fill(32'h0000_0800, 2'd2);
        ack_delay = 0;

        // Replacement: tags 3, 4, 5 then tag 1 has been evicted.
        fill(32'h0000_0C00, 2'd1);
        fill(32'h0000_1000, 2'd0);
        fill(32'h0000_1400, 2'd3);
        fill(32'h0000_0400, 2'd2);
        check_stats("mid");

        // Disabled cache: no hit, no fill.
        en = 1'b0;
        lookup(32'h0000_0400, 1'b0, 7'd0);
        check_val("en_off_busy", 32'(busy), 32'd0);
        en = 1'b1;
        lookup(32'h0000_0400, 1'b1, 7'h40);

        // Flush during beat 2 with slow ACK: beats 0..2 written, no beat 3.
        ack_delay = 3;
        push_fill(32'h0000_1800, 2'd1, 3);
        lookup(32'h0000_1800, 1'b0, 7'd0);
        n = 0;
        while (sb.size() != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("flush_sync", 32'(sb.size()), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        wait_idle();
        ack_delay = 0;
        check_stats("flush_fill");

        // Everything misses after the flush; tag 1 is still owned by seg2.
        fill(32'h0000_0400, 2'd2);
        lookup(32'h0000_0400, 1'b1, 7'h40);
        lookup(32'h0000_0420, 1'b1, 7'h41);
        lookup(32'h0000_0460, 1'b1, 7'h43);
        fill(32'h0000_1480, 2'd3);
        check_stats("three_two");

        // Flush in IDLE: present bits and counters cleared, tags kept.
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        check_stats("flush_idle");
        fill(32'h0000_0400, 2'd2);
        lookup(32'h0000_0400, 1'b1, 7'h40);
        check_stats("final");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tms34020_cache_fill.md
TMS34020_CACHE_FILL -- requirements
Module: tms34020_cache_fill

Interface
REQ-001 SHALL have parameter TAG_W, default 22, tag width (fetch address bits 31:10).
REQ-002 SHALL have ports: CLK  in  1  system clock.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 EN  in  1  cache enable.
REQ-005 FLUSH  in  1  single-cycle pulse, invalidates all subsegments.
REQ-006 FETCH_REQ  in  1  instruction fetch lookup strobe.
REQ-007 FETCH_ADDR  in  32  bit address; word=[6:5], subseg=[9:7], tag=[31:10]; [4:0] ignored.
REQ-008 HIT  out  1  lookup hit, combinational from FETCH_REQ/FETCH_ADDR.
REQ-009 RADDR  out  7  cache RAM read address {seg,subseg,word}.
REQ-010 BUSY  out  1  fill in progress.
REQ-011 BUS_REQ  out  1  external word-read request; BUS_ADDR  out  32  bit address, [4:0]=0.
REQ-012 BUS_ACK  in  1  read complete; BUS_DATA  in  32  read data valid with BUS_ACK.
REQ-013 CWADDR  out  7, CWDATA  out  32, CWREN  out  1: cache RAM write port.
REQ-014 HIT_CNT  out  16, MISS_CNT  out  16: statistics.

Function
REQ-015 Structure SHALL be 4 segments x 8 subsegments x 4 words; per segment one TAG_W tag, per subsegment one present bit.
REQ-016 HIT SHALL be 1 iff EN, FETCH_REQ, state IDLE, some segment tag equals FETCH_ADDR[31:10] and its present bit for FETCH_ADDR[9:7] is set; RADDR SHALL then address that word, else RADDR=0.
REQ-017 States SHALL be IDLE and FILL only.
REQ-018 IDLE->FILL on FETCH_REQ & EN & !HIT & !FLUSH; if no tag matches, LRU segment SHALL receive the new tag and have all 8 present bits cleared in that same cycle.
REQ-019 FILL SHALL read the 4 words of the subsegment in order word 0..3 (aligned, not critical-word-first).
REQ-020 BUS_REQ and BUS_ADDR SHALL stay stable from assertion until the cycle BUS_ACK is sampled high; next beat's BUS_REQ asserts the following cycle (1 idle cycle min. between beats not permitted: BUS_REQ stays high, BUS_ADDR advances by 32).
REQ-021 On each BUS_ACK, CWREN=1 for exactly that cycle with CWDATA=BUS_DATA, CWADDR={seg,subseg,beat}.
REQ-022 After the 4th ACK: present bit set, segment made MRU, return to IDLE; re-issued lookup hits the next cycle.
REQ-023 A hit SHALL make its segment MRU; LRU reset order seg0=MRU ... seg3=LRU.
REQ-024 FLUSH in IDLE: all 32 present bits cleared next cycle; tags and LRU unchanged.
REQ-025 FLUSH in FILL: recorded; fill ends after the current beat's ACK (that word still written), present bit not set, all present bits cleared, return to IDLE.
REQ-026 EN=0: HIT=0, no new fill started; a running fill completes normally.
REQ-027 BUSY=1 exactly while state=FILL; FETCH_REQ during FILL SHALL be ignored.

Reset
REQ-028 RST_N low SHALL asynchronously force: state IDLE, present bits 0, tags 0, LRU reset order, BUS_REQ/CWREN/BUSY/HIT 0, BUS_ADDR/CWADDR/CWDATA 0, counters 0.
REQ-029 Reset mid-fill SHALL drop BUS_REQ immediately; no completion of the beat.

Configuration
REQ-030 Macro TMS34020_CACHE_STATS_EN defined: HIT_CNT increments per hit lookup, MISS_CNT per fill start, both saturate at 16'hFFFF, cleared by FLUSH.
REQ-031 Macro undefined: counters not built, HIT_CNT and MISS_CNT tied to 0.

Structure
REQ-032 Package tms34020_cache_pkg SHALL hold: state enum, segment/subsegment/word index widths, LINE_WORDS=4, SEG_NUM=4, LRU stack type.
REQ-033 Sub-module tms34020_cache_lru SHALL hold the 4-entry LRU stack (touch input, LRU segment output).

Verification
REQ-034 Cold miss: reset, FETCH_REQ addr 0x0000_0400 -> tag 1 into seg3, 4 bus reads 0x400,0x420,0x440,0x460, CWADDR 0x60..0x63, then HIT=1, RADDR=0x60.
REQ-035 Subsegment miss same tag: after REQ-034, addr 0x0000_0480 -> fill into seg3 subseg1 only, present bits of subseg0 retained.
REQ-036 Replacement: 5 distinct tags 1..5 filled in order -> tag 1 evicted; addr 0x400 misses again.
REQ-037 Flush mid-fill: FLUSH during beat 2 with ACK delayed 3 cycles -> beat 2 written, no beat 3 request, all lookups miss after.
REQ-038 Back-pressure: BUS_ACK held low 10 cycles -> BUS_REQ/BUS_ADDR stable throughout.
REQ-039 Stats (macro on): 3 hits, 2 misses -> HIT_CNT=3, MISS_CNT=2; FLUSH -> both 0.
